// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a producer and a UART transmitter. First-word fall-through
// head output, sticky overflow flag, synchronous active-high reset.
module uart_tx_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [Width-1:0]         WrData,
  input  logic                     WrValid,
  output logic                     WrReady,
  output logic [Width-1:0]         RdData,
  output logic                     RdValid,
  input  logic                     RdReady,
  output logic [$clog2(Depth):0]   Count,
  output logic                     Overflow,
  input  logic                     ClearOverflow
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic [CntW-1:0]  count;
  logic             overflow;
  logic             wrEn;
  logic             rdEn;

  // Ready/valid derive only from registered occupancy, so a full FIFO drops a
  // write even when a read frees a slot in the same cycle.
  always_comb begin
    WrReady  = (count != FullCount);
    RdValid  = (count != '0);
    RdData   = mem[rdPtr];
    Count    = count;
    Overflow = overflow;
    wrEn     = WrValid && WrReady;
    rdEn     = RdValid && RdReady;
  end

  // Storage is not reset; writes are suppressed while Reset is high.
  always_ff @(posedge Clock) begin
    if (!Reset && wrEn) begin
      mem[wrPtr] <= WrData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrEn) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (rdEn) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      case ({wrEn, rdEn})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      if (WrValid && !WrReady) begin
        overflow <= 1'b1;
      end else if (ClearOverflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
